seq_detector_param: RTL

- Runtime-programmable serial pattern detector; successor to the fixed 3-bit-state sequence detector.
- Pattern and pattern length are loaded at run time, up to MAX_LEN bits.
- Supports overlapping and non-overlapping detection, a qualified input strobe, and a saturating match counter.
- Sits on a serial bit stream inside the tile, with outputs driven to user pins or a monitor.

---
 rtl/seq_detector_param.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector. It supports overlapping and
// non-overlapping matching, a qualified bit strobe and a saturating match counter.
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               input_valid,
  input  logic               input_bit,
  input  logic               pattern_load,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LW-1:0]      pattern_len_in,
  input  logic               overlap_en,
  input  logic               count_clear,
  output logic               output_indicator,
  output logic [CNT_W-1:0]   match_count,
  output logic [LW-1:0]      present_state,
  output logic               armed,
  output logic               cfg_error
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [MAX_LEN-1:0] hist_r, hist_s;
  logic [MAX_LEN-1:0] pattern_r, pattern_s;
  logic [LW-1:0]      fill_r, fill_s;
  logic [LW-1:0]      len_r, len_s;
  logic               ind_r, ind_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic               err_r, err_s;
  logic               match_s;
  logic [LW-1:0]      fill_inc_s;
  logic [MAX_LEN-1:0] mask_s;

  // Next-state, history, fill and counter logic
  always_comb begin
    state_s    = state_r;
    hist_s     = hist_r;
    pattern_s  = pattern_r;
    fill_s     = fill_r;
    len_s      = len_r;
    ind_s      = 1'b0;
    err_s      = err_r;
    count_s    = count_r;
    match_s    = 1'b0;
    // Only the low len bits of the pattern take part in the compare
    mask_s     = {MAX_LEN{1'b1}} >> (LW'(MAX_LEN) - len_r);
    fill_inc_s = (fill_r < len_r) ? (fill_r + 1'b1) : len_r;

    if (pattern_load) begin
      pattern_s = pattern_in;
      len_s     = pattern_len_in;
      hist_s    = {MAX_LEN{1'b0}};
      fill_s    = {LW{1'b0}};
      if ((pattern_len_in == {LW{1'b0}}) || (pattern_len_in > LW'(MAX_LEN))) begin
        state_s = IDLE;
        err_s   = 1'b1;
      end else begin
        state_s = RUN;
        err_s   = 1'b0;
      end
    end else begin
      case (state_r)
        RUN: begin
          if (input_valid) begin
            hist_s = {hist_r[MAX_LEN-2:0], input_bit};
            fill_s = fill_inc_s;
            if ((fill_inc_s == len_r) && ((hist_s & mask_s) == (pattern_r & mask_s))) begin
              match_s = 1'b1;
              ind_s   = 1'b1;
              fill_s  = overlap_en ? len_r : {LW{1'b0}};
            end else begin
              match_s = 1'b0;
            end
          end else begin
            fill_s = fill_r;
          end
        end
        IDLE: begin
          fill_s = {LW{1'b0}};
        end
        default: begin
          state_s = IDLE;
          fill_s  = {LW{1'b0}};
        end
      endcase
    end

    // A clear beats a coincident match; the pulse itself is unaffected
    if (count_clear) begin
      count_s = {CNT_W{1'b0}};
    end else if (match_s && (count_r != {CNT_W{1'b1}})) begin
      count_s = count_r + 1'b1;
    end else begin
      count_s = count_r;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= IDLE;
      hist_r    <= {MAX_LEN{1'b0}};
      pattern_r <= {MAX_LEN{1'b0}};
      fill_r    <= {LW{1'b0}};
      len_r     <= {LW{1'b0}};
      ind_r     <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      hist_r    <= hist_s;
      pattern_r <= pattern_s;
      fill_r    <= fill_s;
      len_r     <= len_s;
      ind_r     <= ind_s;
      count_r   <= count_s;
      err_r     <= err_s;
    end
  end

  assign output_indicator = ind_r;
  assign match_count      = count_r;
  assign present_state    = fill_r;
  assign armed            = (state_r == RUN);
  assign cfg_error        = err_r;

endmodule
